mb_repairclk_controller: RTL and testbench
==========================================

MB_REPAIRCLK_CONTROLLER -- requirements
Module: mb_repairclk_controller

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter SETTLE_CYC, default 8, SHALL set the wait in cycles between generator completion and detector result sampling (range 1..255).
REQ-003 Parameter TIMEOUT_CYC, default 1024, SHALL set the maximum GEN-state cycles allowed before a timeout (range 2..65535).
REQ-004 Parameter MAX_RETRY, default 2, SHALL set the number of re-attempts allowed after a failed check (range 0..7).
REQ-005 i_clk  in  1  SHALL be the system clock for all state.
REQ-006 i_rst  in  1  SHALL be the asynchronous active-high reset.
REQ-007 i_start  in  1  SHALL be a single-cycle request to run the repair-clock sequence.
REQ-008 i_abort  in  1  SHALL be a single-cycle request to cancel a running sequence.
REQ-009 i_gen_done  in  1  SHALL be the completion flag from the clock mode generator.
REQ-010 i_result_logged  in  3  SHALL carry the detector result {Track,CKN,CKP}; 1 means pattern seen.
REQ-011 o_clear  out  1  SHALL be the detector clear pulse.
REQ-012 o_state_indicator  out  1  SHALL drive the generator repair-mode enable.
REQ-013 o_busy  out  1  SHALL be high in every state except IDLE.
REQ-014 o_done  out  1  SHALL be a one-cycle sequence-complete pulse.
REQ-015 o_pass / o_fail / o_timeout  out  1 each  SHALL be sticky status flags.
REQ-016 o_result  out  3  SHALL be the last latched i_result_logged.
REQ-017 o_retry_cnt  out  3  SHALL be the number of retries used in the current or last run.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, GEN, SETTLE, CHECK and DONE.
REQ-019 IDLE: i_start=1 -> CLEAR; pass/fail/timeout/result/retry_cnt cleared on the same edge.
REQ-020 i_start SHALL be ignored in every state other than IDLE.
REQ-021 CLEAR: o_clear=1 for exactly one cycle, then -> GEN; the GEN timer is reset to 0.
REQ-022 GEN: o_state_indicator=1 (registered output) and the timer increments each cycle.
REQ-023 In GEN, i_gen_done=1 -> SETTLE.
REQ-024 In GEN, timer==TIMEOUT_CYC-1 with i_gen_done=0 -> DONE with o_fail=1 and o_timeout=1.
REQ-025 In GEN, if i_gen_done=1 and timeout coincide on the same edge, done SHALL win.
REQ-026 SETTLE: o_state_indicator=0; the block SHALL wait exactly SETTLE_CYC cycles, then -> CHECK.
REQ-027 CHECK (one cycle): o_result <= i_result_logged.
REQ-028 In CHECK, result==3'b111 -> DONE with o_pass=1.
REQ-029 In CHECK, result!=3'b111 and retry_cnt<MAX_RETRY -> retry_cnt+1, -> CLEAR.
REQ-030 In CHECK, result!=3'b111 and retry_cnt==MAX_RETRY -> DONE with o_fail=1.
REQ-031 DONE: o_done=1 for one cycle, then -> IDLE; status flags SHALL hold until the next accepted i_start.
REQ-032 Latency: i_start sampled at edge k -> o_clear high in cycle k+1 and o_state_indicator high from cycle k+2.
REQ-033 Latency: i_gen_done sampled at edge m -> o_done high in cycle m+SETTLE_CYC+2.
REQ-034 i_abort in any non-IDLE state -> IDLE next edge with no o_done; o_state_indicator and o_clear drop; o_fail=1; other flags unchanged.
REQ-035 i_abort SHALL have priority over every other transition; i_abort in IDLE SHALL have no effect.
REQ-036 The timer and settle counters SHALL saturate and never wrap.
REQ-037 The timer and settle counters SHALL be sized with $clog2 of their parameter.
REQ-038 o_pass and o_fail SHALL never be high simultaneously.

Reset
REQ-039 i_rst=1 SHALL force IDLE asynchronously, clear all outputs and counters to 0, and apply mid-sequence with no o_done.
REQ-040 The first i_start after reset deassertion SHALL be accepted normally.

Verification
REQ-041 Pass path (SETTLE_CYC=8): i_start at edge 0, i_gen_done at edge 10, result 3'b111 -> o_done in cycle 20, o_pass=1, o_retry_cnt=0.
REQ-042 Retry path (MAX_RETRY=2): result 3'b101, then 3'b111 -> two o_clear pulses, o_pass=1, o_retry_cnt=1, o_result=3'b111.
REQ-043 Retry exhaustion: result 3'b000 on all checks -> three o_clear pulses, o_fail=1, o_retry_cnt=2, o_result=3'b000.
REQ-044 Timeout (TIMEOUT_CYC=16): i_gen_done held 0 -> o_done 17 cycles after CLEAR, o_fail=1, o_timeout=1; done coincident with the last timer cycle -> SETTLE entered, no timeout.
REQ-045 Abort/reset: i_abort during SETTLE -> IDLE next edge, o_fail=1, no o_done; i_rst pulse during GEN -> all outputs 0 immediately; i_start while busy -> no effect.

Source files
------------

// File: rtl/mb_repairclk_controller.sv
// rtl/mb_repairclk_controller.sv - repair-clock sequence controller (clear, generate, settle, check, retry)
//
// Runs the repair-clock check: clears the detector, enables the clock mode
// generator until it reports completion (or a timeout expires), waits for the
// detector to settle, then samples the detector result. A failed check is
// retried up to MAX_RETRY times.
//
// Ports:
//   i_clk              system clock
//   i_rst              asynchronous active-high reset
//   i_start            single-cycle request to run the sequence (IDLE only)
//   i_abort            single-cycle request to cancel a running sequence
//   i_gen_done         completion flag from the clock mode generator
//   i_result_logged    detector result {Track,CKN,CKP}, 1 = pattern seen
//   o_clear            detector clear pulse (CLEAR state)
//   o_state_indicator  generator repair-mode enable (registered, GEN state)
//   o_busy             high whenever the FSM is not IDLE
//   o_done             one-cycle sequence-complete pulse
//   o_pass/o_fail/o_timeout  sticky status, cleared by an accepted i_start
//   o_result           last latched detector result
//   o_retry_cnt        retries used in the current or last run
module mb_repairclk_controller #(
   parameter int SETTLE_CYC  = 8,
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_RETRY   = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic       i_gen_done,
   input  logic [2:0] i_result_logged,
   output logic       o_clear,
   output logic       o_state_indicator,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic       o_fail,
   output logic       o_timeout,
   output logic [2:0] o_result,
   output logic [2:0] o_retry_cnt
);

   // Counters only ever need to reach PARAM-1; guard the width for PARAM=1.
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_GEN,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [SW-1:0] settle, settle_n;
   logic [2:0]    retry_n, result_n;
   logic          pass_n, fail_n, timeout_n, si_n;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state             <= S_IDLE;
         timer             <= '0;
         settle            <= '0;
         o_retry_cnt       <= '0;
         o_result          <= '0;
         o_pass            <= 1'b0;
         o_fail            <= 1'b0;
         o_timeout         <= 1'b0;
         o_state_indicator <= 1'b0;
      end else begin
         state             <= state_n;
         timer             <= timer_n;
         settle            <= settle_n;
         o_retry_cnt       <= retry_n;
         o_result          <= result_n;
         o_pass            <= pass_n;
         o_fail            <= fail_n;
         o_timeout         <= timeout_n;
         o_state_indicator <= si_n;
      end
   end

   always_comb begin
      state_n   = state;
      timer_n   = timer;
      settle_n  = settle;
      retry_n   = o_retry_cnt;
      result_n  = o_result;
      pass_n    = o_pass;
      fail_n    = o_fail;
      timeout_n = o_timeout;

      case (state)
         S_IDLE: begin
            if (i_start) begin
               state_n   = S_CLEAR;
               pass_n    = 1'b0;
               fail_n    = 1'b0;
               timeout_n = 1'b0;
               result_n  = '0;
               retry_n   = '0;
            end
         end
         S_CLEAR: begin
            state_n = S_GEN;
            timer_n = '0;
         end
         S_GEN: begin
            // Completion is checked first so it wins over a coincident timeout.
            if (i_gen_done) begin
               state_n  = S_SETTLE;
               settle_n = '0;
            end else if (timer == TIMER_LAST) begin
               state_n   = S_DONE;
               fail_n    = 1'b1;
               timeout_n = 1'b1;
            end else if (timer != {TW{1'b1}}) begin
               timer_n = timer + 1'b1;
            end
         end
         S_SETTLE: begin
            if (settle == SETTLE_LAST) begin
               state_n = S_CHECK;
            end else if (settle != {SW{1'b1}}) begin
               settle_n = settle + 1'b1;
            end
         end
         S_CHECK: begin
            result_n = i_result_logged;
            if (i_result_logged == 3'b111) begin
               state_n = S_DONE;
               pass_n  = 1'b1;
            end else if (o_retry_cnt < RETRY_MAX) begin
               state_n = S_CLEAR;
               retry_n = o_retry_cnt + 1'b1;
            end else begin
               state_n = S_DONE;
               fail_n  = 1'b1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Abort overrides everything above. Pass is dropped so pass and fail
      // can never be set together (abort landing in the DONE cycle).
      if (i_abort && (state != S_IDLE)) begin
         state_n   = S_IDLE;
         timer_n   = timer;
         settle_n  = settle;
         retry_n   = o_retry_cnt;
         result_n  = o_result;
         timeout_n = o_timeout;
         pass_n    = 1'b0;
         fail_n    = 1'b1;
      end

      si_n = (state_n == S_GEN);
   end

   assign o_clear = (state == S_CLEAR);
   assign o_busy  = (state != S_IDLE);
   assign o_done  = (state == S_DONE) && !i_abort;

endmodule

// File: tb/tb_mb_repairclk_controller.sv
// tb/tb_mb_repairclk_controller.sv - self-checking bench for mb_repairclk_controller
module tb_mb_repairclk_controller;

   localparam int S  = 8;
   localparam int TO = 16;
   localparam int MR = 2;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic       i_abort = 1'b0;
   logic       i_gen_done = 1'b0;
   logic [2:0] i_result_logged = 3'b000;
   logic       o_clear, o_state_indicator, o_busy, o_done;
   logic       o_pass, o_fail, o_timeout;
   logic [2:0] o_result, o_retry_cnt;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   mb_repairclk_controller #(
      .SETTLE_CYC (S),
      .TIMEOUT_CYC(TO),
      .MAX_RETRY  (MR)
   ) dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .i_start          (i_start),
      .i_abort          (i_abort),
      .i_gen_done       (i_gen_done),
      .i_result_logged  (i_result_logged),
      .o_clear          (o_clear),
      .o_state_indicator(o_state_indicator),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_pass           (o_pass),
      .o_fail           (o_fail),
      .o_timeout        (o_timeout),
      .o_result         (o_result),
      .o_retry_cnt      (o_retry_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Per attempt: d = GEN cycles with gen_done low before it is raised
   // (d >= TO means never), r = detector result presented for that attempt.
   typedef struct packed {
      logic [2:0][7:0] d;
      logic [2:0][2:0] r;
      logic            xs;   // extra i_start pulse while busy
   } stim_t;

   typedef struct packed {
      logic [7:0]  clears;
      logic [15:0] off;      // cycles from first o_clear to o_done
      logic        pass;
      logic        fail;
      logic        tmo;
      logic [2:0]  retry;
      logic [2:0]  result;
   } exp_t;

   typedef struct packed {
      stim_t s;
      exp_t  e;
   } vec_t;

   vec_t tbl [7];

   function automatic stim_t mk(int d0, int d1, int d2, int r0, int r1, int r2, bit xs);
      stim_t s;
      s.d  = {8'(d2), 8'(d1), 8'(d0)};
      s.r  = {3'(r2), 3'(r1), 3'(r0)};
      s.xs = xs;
      return s;
   endfunction

   function automatic exp_t mke(int cl, int off, bit p, bit f, bit t, int rt, int rs);
      exp_t e;
      e.clears = 8'(cl);
      e.off    = 16'(off);
      e.pass   = p;
      e.fail   = f;
      e.tmo    = t;
      e.retry  = 3'(rt);
      e.result = 3'(rs);
      return e;
   endfunction

   // Reference: sum the length of each attempt (clear + gen + settle + check)
   // and apply the pass / retry / give-up rules.
   function automatic exp_t model(stim_t s);
      exp_t e;
      int   tot;
      int   retries;
      e = '0;
      tot = 0;
      retries = 0;
      for (int a = 0; a < 3; a++) begin
         e.clears = 8'(a + 1);
         if (int'(s.d[a]) >= TO) begin
            tot += 1 + TO;
            e.fail = 1'b1;
            e.tmo  = 1'b1;
            break;
         end
         tot += 1 + (int'(s.d[a]) + 1) + S + 1;
         e.result = s.r[a];
         if (s.r[a] == 3'b111) begin
            e.pass = 1'b1;
            break;
         end
         if (retries < MR) retries++;
         else begin
            e.fail = 1'b1;
            break;
         end
      end
      e.off   = 16'(tot);
      e.retry = 3'(retries);
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_txn(input stim_t s, input exp_t e, input string nm);
      int clears, gen_cnt, att, idx, c0, cd, a_cyc, si_first, both;
      bit done_seen;
      clears = 0; gen_cnt = 0; att = -1; c0 = 0; cd = 0; si_first = -1; both = 0;
      done_seen = 1'b0;
      @(negedge clk);
      i_start = 1'b1;
      a_cyc = cyc;
      for (int k = 0; k < 2000 && !done_seen; k++) begin
         @(negedge clk);
         i_start    = 1'b0;
         i_gen_done = 1'b0;
         if (o_pass && o_fail) both++;
         if (o_clear) begin
            clears++;
            if (clears == 1) c0 = cyc;
            att++;
            gen_cnt = 0;
         end
         if (o_state_indicator) begin
            if (si_first < 0) si_first = cyc;
            idx = (att > 2) ? 2 : ((att < 0) ? 0 : att);
            if (s.xs && gen_cnt == 2) i_start = 1'b1;
            if (gen_cnt == int'(s.d[idx])) begin
               i_gen_done      = 1'b1;
               i_result_logged = s.r[idx];
            end
            gen_cnt++;
         end
         if (o_done) begin
            done_seen = 1'b1;
            cd = cyc;
         end
      end
      i_start    = 1'b0;
      i_gen_done = 1'b0;
      chk({nm, " done_seen"}, int'(done_seen), 1);
      chk({nm, " clear_lat"}, c0 - a_cyc, 1);
      chk({nm, " si_lat"}, si_first - c0, 1);
      chk({nm, " clears"}, clears, int'(e.clears));
      chk({nm, " done_off"}, cd - c0, int'(e.off));
      chk({nm, " pass"}, int'(o_pass), int'(e.pass));
      chk({nm, " fail"}, int'(o_fail), int'(e.fail));
      chk({nm, " timeout"}, int'(o_timeout), int'(e.tmo));
      chk({nm, " retry"}, int'(o_retry_cnt), int'(e.retry));
      chk({nm, " result"}, int'(o_result), int'(e.result));
      chk({nm, " pass_and_fail"}, both, 0);
      @(negedge clk);
      chk({nm, " done_1cyc"}, int'(o_done), 0);
      chk({nm, " idle_busy"}, int'(o_busy), 0);
      chk({nm, " pass_held"}, int'(o_pass), int'(e.pass));
   endtask

   initial begin
      stim_t rs;
      int    dcnt;
      bit    seen;

      tbl[0] = '{s: mk(8, 0, 0, 7, 0, 0, 0),   e: mke(1, 19, 1, 0, 0, 0, 7)};
      tbl[1] = '{s: mk(3, 5, 0, 5, 7, 0, 0),   e: mke(2, 30, 1, 0, 0, 1, 7)};
      tbl[2] = '{s: mk(0, 0, 0, 0, 0, 0, 0),   e: mke(3, 33, 0, 1, 0, 2, 0)};
      tbl[3] = '{s: mk(100, 0, 0, 7, 0, 0, 0), e: mke(1, 17, 0, 1, 1, 0, 0)};
      tbl[4] = '{s: mk(15, 0, 0, 7, 0, 0, 0),  e: mke(1, 26, 1, 0, 0, 0, 7)};
      tbl[5] = '{s: mk(2, 100, 0, 3, 7, 0, 0), e: mke(2, 30, 0, 1, 1, 1, 3)};
      tbl[6] = '{s: mk(4, 0, 0, 7, 0, 0, 1),   e: mke(1, 15, 1, 0, 0, 0, 7)};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_outputs", int'({o_clear, o_state_indicator, o_busy, o_done, o_pass,
                               o_fail, o_timeout, o_result, o_retry_cnt}), 0);
      i_rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", int'(o_busy), 0);

      // Directed table
      for (int v = 0; v < 7; v++) run_txn(tbl[v].s, tbl[v].e, $sformatf("vec%0d", v));

      // Abort in IDLE has no effect (last vector passed)
      @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("idle_abort_fail", int'(o_fail), 0);
      chk("idle_abort_pass", int'(o_pass), 1);
      chk("idle_abort_busy", int'(o_busy), 0);

      // Abort during SETTLE
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (o_state_indicator) seen = 1'b1;
      end
      chk("abort_reach_gen", int'(seen), 1);
      i_gen_done = 1'b1;
      i_result_logged = 3'b111;
      @(negedge clk);
      i_gen_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_in_settle", int'({o_busy, o_state_indicator}), 2);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_fail", int'(o_fail), 1);
      chk("abort_pass", int'(o_pass), 0);
      chk("abort_timeout", int'(o_timeout), 0);
      dcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (o_done) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);

      // Asynchronous reset during GEN
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      chk("rst_gen_si", int'(o_state_indicator), 1);
      i_rst = 1'b1;
      #1;
      chk("rst_async_outputs", int'({o_clear, o_state_indicator, o_busy, o_done, o_pass,
                                     o_fail, o_timeout, o_result, o_retry_cnt}), 0);
      @(negedge clk);
      i_rst = 1'b0;
      dcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (o_done || o_busy) dcnt++;
      end
      chk("rst_stays_idle", dcnt, 0);

      // First start after reset is accepted normally
      run_txn(tbl[0].s, tbl[0].e, "after_rst");

      // Randomized transactions against the reference model
      for (int t = 0; t < 24; t++) begin
         rs.xs = 1'b0;
         for (int a = 0; a < 3; a++) begin
            rs.d[a] = 8'($urandom_range(0, 19));
            rs.r[a] = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
         end
         run_txn(rs, model(rs), $sformatf("rnd%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
